// File: rtl/car_gen.sv
// Car sequence generator: plays a four-phase sensor pattern for one car
// arriving or leaving, and keeps a saturating count of cars inside.
module car_gen #(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       dir,
    output logic       sens1,
    output logic       sens2,
    output logic       busy,
    output logic       done,
    output logic [6:0] net
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        P12  = 3'd2,
        P2   = 3'd3,
        GAP  = 3'd4
    } state_t;

    localparam logic [7:0] LAST = 8'(DWELL - 1);
    localparam logic [6:0] NET_MAX = 7'd99;

    state_t     state, state_nx;
    logic [7:0] dwell_cnt, dwell_nx;
    logic       dir_q, dir_nx;
    logic [1:0] sens_nx;
    logic       busy_nx, done_nx;
    logic [6:0] net_nx;
    logic       last;

    // {sens2,sens1} for a state; leave is the mirror image of arrive
    function automatic logic [1:0] sens_for(input state_t s, input logic arrive);
        logic [1:0] v;
        v = 2'b00;
        case (s)
            P1:      v = arrive ? 2'b10 : 2'b01;
            P12:     v = 2'b11;
            P2:      v = arrive ? 2'b01 : 2'b10;
            default: v = 2'b00;
        endcase
        return v;
    endfunction

    always_comb begin
        state_nx = state;
        dwell_nx = dwell_cnt;
        dir_nx   = dir_q;
        done_nx  = 1'b0;
        net_nx   = net;
        last     = (dwell_cnt == LAST);

        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = P1;
                    dir_nx   = dir;
                    dwell_nx = '0;
                end
            end
            P1, P12, P2, GAP: begin
                if (last) begin
                    dwell_nx = '0;
                    case (state)
                        P1:  state_nx = P12;
                        P12: state_nx = P2;
                        P2:  state_nx = GAP;
                        default: begin
                            state_nx = IDLE;
                            done_nx  = 1'b1;
                            if (dir_q)
                                net_nx = (net == NET_MAX) ? net : net + 7'd1;
                            else
                                net_nx = (net == 7'd0) ? net : net - 7'd1;
                        end
                    endcase
                end else begin
                    dwell_nx = dwell_cnt + 8'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                dwell_nx = '0;
            end
        endcase

        // Outputs are registered, so they are derived from the next state
        busy_nx = (state_nx != IDLE);
        sens_nx = sens_for(state_nx, dir_nx);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            dwell_cnt <= '0;
            dir_q     <= 1'b0;
            sens1     <= 1'b0;
            sens2     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            net       <= '0;
        end else begin
            state     <= state_nx;
            dwell_cnt <= dwell_nx;
            dir_q     <= dir_nx;
            sens2     <= sens_nx[1];
            sens1     <= sens_nx[0];
            busy      <= busy_nx;
            done      <= done_nx;
            net       <= net_nx;
        end
    end

endmodule

// File: tb/tb_car_gen.sv
// Bench for car_gen: per-cycle comparison against a countdown reference model,
// directed scenarios plus random start/dir/reset traffic.
module tb_car_gen;

    localparam int unsigned DWELL = 4;
    localparam int SEQ = 4 * DWELL;

    logic       clk = 1'b0;
    logic       reset, start, dir;
    logic       sens1, sens2, busy, done;
    logic [6:0] net;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: remaining busy cycles, latched direction, done, net
    int m_rem, m_net;
    bit m_done, m_dir;
    int arr_tab[4] = '{2, 3, 1, 0};
    int lev_tab[4] = '{1, 3, 2, 0};

    // loopback car counter fed by the sensors
    logic [7:0] hist;
    int         lb_cnt;

    always #5 clk = ~clk;

    car_gen #(.DWELL(DWELL)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .dir   (dir),
        .sens1 (sens1),
        .sens2 (sens2),
        .busy  (busy),
        .done  (done),
        .net   (net)
    );

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist   <= 8'h00;
            lb_cnt <= 0;
        end else if ({sens2, sens1} != hist[1:0]) begin
            hist <= {hist[5:0], sens2, sens1};
            if ({sens2, sens1} == 2'b00 && hist[5:0] == 6'b10_11_01)
                lb_cnt <= lb_cnt + 1;
            else if ({sens2, sens1} == 2'b00 && hist[5:0] == 6'b01_11_10 && lb_cnt > 0)
                lb_cnt <= lb_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rem  = 0;
        m_net  = 0;
        m_done = 0;
        m_dir  = 0;
    endtask

    task automatic model_step(input bit st, input bit d);
        if (m_rem == 0) begin
            m_done = 0;
            if (st) begin
                m_rem = SEQ;
                m_dir = d;
            end
        end else begin
            m_rem--;
            if (m_rem == 0) begin
                m_done = 1;
                if (m_dir) m_net = (m_net == 99) ? 99 : m_net + 1;
                else       m_net = (m_net == 0) ? 0 : m_net - 1;
            end
        end
    endtask

    task automatic compare_all();
        int phase, v;
        v = 0;
        if (m_rem > 0) begin
            phase = (SEQ - m_rem) / DWELL;
            v = m_dir ? arr_tab[phase] : lev_tab[phase];
        end
        check("sens", {30'd0, sens2, sens1}, v);
        check("busy", {31'd0, busy}, (m_rem > 0) ? 1 : 0);
        check("done", {31'd0, done}, m_done);
        check("net", {25'd0, net}, m_net);
    endtask

    task automatic cycle(input bit st, input bit d);
        start = st;
        dir   = d;
        @(posedge clk);
        model_step(st, d);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0);
    endtask

    // reset applied away from the edge; outputs must clear before any clock
    task automatic pulse_reset();
        start = 0;
        reset = 1;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        int dones;
        reset = 1;
        start = 0;
        dir   = 0;
        model_reset();
        #2;
        compare_all();
        @(negedge clk);
        reset = 0;

        // single arrive
        cycle(1, 1);
        idle(SEQ + 1);
        check("arrive_net", {25'd0, net}, 1);

        // two leaves; second one holds at 0
        cycle(1, 0);
        idle(SEQ + 1);
        cycle(1, 0);
        idle(SEQ + 1);
        check("leave_floor", {25'd0, net}, 0);

        // start pulses during busy are ignored
        dones = 0;
        cycle(1, 1);
        for (int i = 1; i <= SEQ + 2; i++) begin
            cycle(i == 3 || i == 9, !(i == 3 || i == 9));
            if (done) dones++;
        end
        check("ignore_dones", dones, 1);

        // start held high: back-to-back sequences, saturation at 99
        dones = 0;
        for (int i = 0; i < 2200 && dones < 101; i++) begin
            cycle(1, 1);
            if (done) dones++;
        end
        check("sat_dones", dones, 101);
        check("sat_net", {25'd0, net}, 99);
        idle(3);

        // reset while in P12 of an arrive
        cycle(1, 1);
        idle(DWELL + 1);
        check("p12_sens", {30'd0, sens2, sens1}, 3);
        pulse_reset();
        cycle(1, 1);
        idle(SEQ + 1);
        check("post_reset_net", {25'd0, net}, 1);

        // loopback into a car counter: 5 arrivals, 2 leaves
        pulse_reset();
        for (int i = 0; i < 7; i++) begin
            cycle(1, i < 5);
            idle(SEQ + 1);
        end
        check("loop_disp", {24'd0, 4'(lb_cnt / 10), 4'(lb_cnt % 10)}, 32'h03);
        check("loop_net", {25'd0, net}, 3);

        // random traffic
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 199) == 0)
                pulse_reset();
            else
                cycle($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/car_gen.md
CAR_GEN -- requirements
Module: car_gen

Interface
REQ-001 The module SHALL have parameter DWELL, default 4, meaning clock cycles each sensor phase is held (legal range 1..255).
REQ-002 The module SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 The module SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The module SHALL have port start  input  1  request to emit one car sequence, sampled only in IDLE.
REQ-005 The module SHALL have port dir  input  1  direction, sampled with start: 1 = arrive, 0 = leave.
REQ-006 The module SHALL have port sens1  output  1  registered sensor-1 drive.
REQ-007 The module SHALL have port sens2  output  1  registered sensor-2 drive.
REQ-008 The module SHALL have port busy  output  1  high while a sequence is in progress.
REQ-009 The module SHALL have port done  output  1  one-cycle pulse on completion of a sequence.
REQ-010 The module SHALL have port net  output  7  saturating count of cars currently inside (0..99).

Function
REQ-011 The FSM SHALL have states IDLE, P1, P12, P2, GAP; a dwell counter of 8 bits times each non-IDLE state for exactly DWELL cycles.
REQ-012 In IDLE with start=1 at a rising edge, the FSM SHALL latch dir, enter P1, and assert busy from the next cycle.
REQ-013 Arrive ({sens2,sens1}) SHALL be driven as P1=10, P12=11, P2=01, GAP=00.
REQ-014 Leave ({sens2,sens1}) SHALL be driven as P1=01, P12=11, P2=10, GAP=00.
REQ-015 Each of P1, P12, P2, GAP SHALL last exactly DWELL cycles, giving busy high for exactly 4*DWELL cycles per sequence.
REQ-016 Sensors SHALL change only at state transitions; no other sensor value SHALL ever appear (no 11->00 or 10<->01 direct steps).
REQ-017 On the edge leaving GAP, the FSM SHALL return to IDLE, deassert busy, and pulse done for exactly one cycle.
REQ-018 On that same edge net SHALL be incremented for arrive (held at 99 if already 99) or decremented for leave (held at 0 if already 0).
REQ-019 start asserted while busy SHALL be ignored; dir changes while busy SHALL not affect the sequence in progress.
REQ-020 start held high continuously SHALL launch a new sequence on the cycle done is high (back-to-back, one IDLE cycle between sequences).
REQ-021 Unreachable state encodings SHALL recover to IDLE on the next edge with sensors 00.
REQ-022 sens1, sens2, busy, done, net SHALL be driven directly from flops (no combinational path from start/dir).

Reset
REQ-023 Reset SHALL asynchronously force state=IDLE, dwell counter=0, sens1=0, sens2=0, busy=0, done=0, net=0.
REQ-024 Reset asserted mid-sequence SHALL abort it with no net update and no done pulse; operation SHALL resume on the first edge after reset deasserts.

Verification
REQ-025 DWELL=4, start=1 dir=1 for one cycle -> {sens2,sens1} = 10 x4, 11 x4, 01 x4, 00 x4 cycles; busy 16 cycles; done one cycle; net 0->1.
REQ-026 DWELL=4, from net=1, start dir=0 -> 01 x4, 11 x4, 10 x4, 00 x4; done pulse; net 1->0; a further leave -> net stays 0.
REQ-027 Start pulses during busy at cycles 3 and 9 of a sequence -> ignored; exactly one done, net changes by one.
REQ-028 Start held high dir=1 for 100 sequences -> net saturates at 99; 101st done still pulses with net=99; one IDLE cycle between sequences.
REQ-029 Reset asserted in P12 of an arrive -> sensors 00, busy 0 immediately, no done, net unchanged value reset to 0; next start runs a full clean sequence.
REQ-030 Loopback: sens1/sens2 feed the team's car counter at same clk; 5 arrivals and 2 leaves -> counter display reads 03 and net=3.
